square_wave_sequencer: RTL and testbench

Controller that sequences the square wave generator through a programmable table of (M, N) high/low settings. It holds each entry for a fixed number of complete output periods, then advances. Entries are changed only at period boundaries, and the generator is re-primed by its reset on each change. It sits between the register/config logic and the generator: it drives the generator's M, N and RST, and monitors its waveOut.

---
 rtl/square_wave_sequencer.sv | 173 +++++++++++++++++
 tb/tb_square_wave_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_wave_sequencer.sv
// Steps a square wave generator through a table of (M, N) high/low settings, holding each entry for REPS periods.
// Optional wrap-around looping is enabled by defining SEQ_LOOP_EN (adds LOOP input and WRAP output).
module square_wave_sequencer #(
    parameter int B = 4,
    parameter int A = 2,
    parameter int R = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         WE,
    input  logic [A-1:0] WADDR,
    input  logic [B-1:0] WM,
    input  logic [B-1:0] WN,
    input  logic [A-1:0] LAST,
    input  logic [R-1:0] REPS,
    input  logic         START,
    input  logic         STOP,
    input  logic         waveIn,
    output logic [B-1:0] M,
    output logic [B-1:0] N,
    output logic         GEN_RST,
    output logic         BUSY,
    output logic         DONE,
    output logic [A-1:0] IDX
`ifdef SEQ_LOOP_EN
   ,input  logic         LOOP,
    output logic         WRAP
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, PRIME, RUN} state_t;

    state_t       state, state_nx;
    logic [B-1:0] tbl_m [2**A];
    logic [B-1:0] tbl_n [2**A];
    logic [A-1:0] idx, last_q;
    logic [R-1:0] reps_q, count;
    logic [B-1:0] m_q, n_q;
    logic         wave_q;
    logic         done_q;
    logic [B-1:0] rd_m, rd_n;
    logic         skip, period_end, reps_hit, at_last, do_wrap, advance;

    assign rd_m       = tbl_m[idx];
    assign rd_n       = tbl_n[idx];
    assign skip       = (rd_m == '0) || (rd_n == '0);
    assign period_end = waveIn & ~wave_q;
    // reps_q is never zero, so the subtraction cannot wrap.
    assign reps_hit   = (count >= reps_q - R'(1));
    assign at_last    = (idx == last_q);

`ifdef SEQ_LOOP_EN
    logic wrap_q;
    assign do_wrap = LOOP & at_last;
    assign WRAP    = wrap_q;
`else
    assign do_wrap = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_nx;
    end

    // NOTE: defaults at the top of a combinational block keep every path assigned, so no latch is inferred.
    always_comb begin
        state_nx = state;
        advance  = 1'b0;
        case (state)
            IDLE:  if (START && !STOP) state_nx = LOAD;
            LOAD: begin
                if (STOP) begin
                    state_nx = IDLE;
                end else if (skip) begin
                    advance  = 1'b1;
                    state_nx = (at_last && !do_wrap) ? IDLE : LOAD;
                end else begin
                    state_nx = PRIME;
                end
            end
            PRIME: state_nx = STOP ? IDLE : RUN;
            RUN: begin
                if (STOP) begin
                    state_nx = IDLE;
                end else if (period_end && reps_hit) begin
                    advance  = 1'b1;
                    state_nx = (at_last && !do_wrap) ? IDLE : LOAD;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        GEN_RST = (state != RUN);
        BUSY    = (state != IDLE);
    end

    assign M    = m_q;
    assign N    = n_q;
    assign DONE = done_q;
    assign IDX  = idx;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            // NOTE: the table is architecturally reset to zero, so it is built from flops, not a RAM macro.
            for (int i = 0; i < 2**A; i++) begin
                tbl_m[i] <= '0;
                tbl_n[i] <= '0;
            end
            idx    <= '0;
            last_q <= '0;
            reps_q <= R'(1);
            count  <= '0;
            m_q    <= '0;
            n_q    <= '0;
            wave_q <= 1'b1;
            done_q <= 1'b0;
`ifdef SEQ_LOOP_EN
            wrap_q <= 1'b0;
`endif
        end else begin
            if (WE) begin
                tbl_m[WADDR] <= WM;
                tbl_n[WADDR] <= WN;
            end

            // The generator restarts high, so the first RUN cycle must not look like a rising edge.
            wave_q <= (state == PRIME) ? 1'b1 : waveIn;
            done_q <= 1'b0;
`ifdef SEQ_LOOP_EN
            wrap_q <= 1'b0;
`endif

            case (state)
                IDLE: begin
                    if (START && !STOP) begin
                        last_q <= LAST;
                        reps_q <= (REPS == '0) ? R'(1) : REPS;
                        idx    <= '0;
                    end
                end
                LOAD: begin
                    if (!STOP && !skip) begin
                        m_q   <= rd_m;
                        n_q   <= rd_n;
                        count <= '0;
                    end
                end
                RUN: begin
                    if (!STOP && period_end && !reps_hit && count != '1)
                        count <= count + R'(1);
                end
                default: ;
            endcase

            if (advance) begin
                if (!at_last) begin
                    idx <= idx + A'(1);
                end else if (do_wrap) begin
                    idx <= '0;
`ifdef SEQ_LOOP_EN
                    wrap_q <= 1'b1;
`endif
                end else begin
                    done_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_square_wave_sequencer.sv
// Self-checking bench: drives a square wave generator model from M/N/GEN_RST and compares every cycle
// against an expected-output timeline expanded from the table, LAST and REPS.
module tb_square_wave_sequencer;

    localparam int B = 4;
    localparam int A = 2;
    localparam int R = 8;

    localparam int W_DONE     = 0;
    localparam int W_GEN_LOW  = 1;
    localparam int W_IDX1_RUN = 2;
    localparam int W_WRAP     = 3;

    logic         CLK = 1'b0;
    logic         RST;
    logic         WE;
    logic [A-1:0] WADDR;
    logic [B-1:0] WM, WN;
    logic [A-1:0] LAST;
    logic [R-1:0] REPS;
    logic         START, STOP;
    logic         waveIn;
    logic [B-1:0] M, N;
    logic         GEN_RST, BUSY, DONE;
    logic [A-1:0] IDX;
`ifdef SEQ_LOOP_EN
    logic         LOOP;
    logic         WRAP;
`endif

    square_wave_sequencer #(.B(B), .A(A), .R(R)) dut (
        .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WM(WM), .WN(WN),
        .LAST(LAST), .REPS(REPS), .START(START), .STOP(STOP), .waveIn(waveIn),
        .M(M), .N(N), .GEN_RST(GEN_RST), .BUSY(BUSY), .DONE(DONE), .IDX(IDX)
`ifdef SEQ_LOOP_EN
       ,.LOOP(LOOP), .WRAP(WRAP)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for one cycle; tail marks the final cycle of an entry.
    typedef struct {
        bit busy;
        bit gen_rst;
        bit done;
        bit wrap;
        bit tail;
        int idx;
        int m;
        int n;
    } exp_t;

    exp_t q[$];
    int   tm[2**A];
    int   tn[2**A];
    int   hold_idx, hold_m, hold_n;
    int   last_l, reps_l, gen_idx;
    bit   model_on = 1'b0;

    function automatic exp_t mk(bit busy, bit gr, bit done, bit wrap, bit tail, int idx, int m, int n);
        exp_t e;
        e.busy = busy; e.gen_rst = gr; e.done = done; e.wrap = wrap;
        e.tail = tail; e.idx = idx; e.m = m; e.n = n;
        return e;
    endfunction

    function automatic bit loop_now();
`ifdef SEQ_LOOP_EN
        return LOOP;
`else
        return 1'b0;
`endif
    endfunction

    // An entry is a single LOAD cycle if skipped, otherwise LOAD + PRIME + REPS whole periods of RUN
    // plus the cycle in which the final rising edge is observed.
    task automatic gen_entry(input int i, input bit wrap);
        int m, n, runs;
        m = tm[i];
        n = tn[i];
        if (m == 0 || n == 0) begin
            q.push_back(mk(1, 1, 0, wrap, 1, i, hold_m, hold_n));
        end else begin
            runs = reps_l * (m + n);
            q.push_back(mk(1, 1, 0, wrap, 0, i, hold_m, hold_n));
            q.push_back(mk(1, 1, 0, 0, 0, i, m, n));
            for (int k = 0; k <= runs; k++)
                q.push_back(mk(1, 0, 0, 0, k == runs, i, m, n));
        end
    endtask

    // Generator model: high for M cycles then low for N, restarting high after its reset.
    initial begin
        int p;
        bit rp;
        int sum;
        p = 0;
        waveIn = 1'b0;
        forever begin
            @(negedge CLK);
            rp  = GEN_RST;
            sum = int'(M) + int'(N);
            @(posedge CLK);
            #2;
            if (rp || sum == 0) p = 0;
            else                p = (p + 1) % sum;
            waveIn = (p < int'(M));
        end
    end

    // Compare process: one expected entry per cycle, then update the model with this cycle's inputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (model_on) begin
                if (q.size() > 0) e = q.pop_front();
                else              e = mk(0, 1, 0, 0, 0, hold_idx, hold_m, hold_n);
                hold_idx = e.idx;
                hold_m   = e.m;
                hold_n   = e.n;
                check("busy", BUSY, e.busy);
                check("gen_rst", GEN_RST, e.gen_rst);
                check("done", DONE, e.done);
                check("idx", IDX, e.idx);
                check("m", M, e.m);
                check("n", N, e.n);
`ifdef SEQ_LOOP_EN
                check("wrap", WRAP, e.wrap);
`endif
                if (!RST) begin
                    q.delete();
                    hold_idx = 0; hold_m = 0; hold_n = 0;
                    for (int i = 0; i < 2**A; i++) begin tm[i] = 0; tn[i] = 0; end
                end else begin
                    if (WE) begin
                        tm[WADDR] = int'(WM);
                        tn[WADDR] = int'(WN);
                    end
                    if (e.busy && STOP) begin
                        q.delete();
                    end else if (e.tail) begin
                        if (gen_idx == last_l) begin
                            if (loop_now()) begin
                                gen_idx = 0;
                                gen_entry(0, 1'b1);
                            end else begin
                                q.push_back(mk(0, 1, 1, 0, 0, gen_idx, hold_m, hold_n));
                            end
                        end else begin
                            gen_idx++;
                            gen_entry(gen_idx, 1'b0);
                        end
                    end else if (!e.busy && START && !STOP) begin
                        last_l  = int'(LAST);
                        reps_l  = (REPS == '0) ? 1 : int'(REPS);
                        gen_idx = 0;
                        gen_entry(0, 1'b0);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic write_entry(input int a, input int m, input int n);
        WE = 1'b1; WADDR = A'(a); WM = B'(m); WN = B'(n);
        tick(1);
        WE = 1'b0;
    endtask

    task automatic pulse_start(input int last, input int reps);
        LAST = A'(last); REPS = R'(reps); START = 1'b1;
        tick(1);
        START = 1'b0;
    endtask

    // Returns the number of negedges until the condition holds, or -1 on timeout.
    task automatic wait_for(input int which, input int budget, output int n);
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge CLK);
            n++;
            case (which)
                W_DONE:     hit = (DONE === 1'b1);
                W_GEN_LOW:  hit = (GEN_RST === 1'b0);
                W_IDX1_RUN: hit = (IDX === A'(1)) && (GEN_RST === 1'b0);
`ifdef SEQ_LOOP_EN
                W_WRAP:     hit = (WRAP === 1'b1);
`endif
                default:    hit = 1'b0;
            endcase
        end
        if (!hit) n = -1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_m"}, M, 0);
        check({tag, "_n"}, N, 0);
        check({tag, "_gen_rst"}, GEN_RST, 1);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_done"}, DONE, 0);
        check({tag, "_idx"}, IDX, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        RST = 1'b0; WE = 1'b0; WADDR = '0; WM = '0; WN = '0;
        LAST = '0; REPS = '0; START = 1'b0; STOP = 1'b0;
`ifdef SEQ_LOOP_EN
        LOOP = 1'b0;
`endif
        tick(2);
        check_reset_values("reset");
        RST = 1'b1;
        hold_idx = 0; hold_m = 0; hold_n = 0;
        model_on = 1'b1;
        tick(1);

        // One-shot, two entries, two periods each.
        write_entry(0, 2, 1);
        write_entry(1, 3, 2);
        pulse_start(1, 2);
        wait_for(W_GEN_LOW, 50, n);
        check("oneshot_gen_low_lat", n, 3);
        wait_for(W_DONE, 100, n);
        check("oneshot_done_lat", n, 20);
        tick(3);

        // Entry 1 is skipped in a single LOAD cycle; REPS=0 behaves as 1.
        write_entry(1, 0, 5);
        write_entry(2, 1, 1);
        pulse_start(2, 1);
        wait_for(W_DONE, 100, n);
        check("skip_done_lat", n, 13);
        tick(2);
        pulse_start(2, 0);
        wait_for(W_DONE, 100, n);
        check("reps0_done_lat", n, 13);

        // STOP mid-RUN at IDX=1, then immediate restart.
        tick(1);
        write_entry(1, 3, 2);
        pulse_start(1, 2);
        wait_for(W_IDX1_RUN, 100, n);
        tick(2);
        STOP = 1'b1;
        tick(1);
        STOP = 1'b0;
        check("stop_busy", BUSY, 0);
        check("stop_gen_rst", GEN_RST, 1);
        check("stop_idx", IDX, 1);
        check("stop_done", DONE, 0);
        pulse_start(1, 1);
        check("restart_idx", IDX, 0);
        check("restart_busy", BUSY, 1);
        wait_for(W_DONE, 100, n);
        check("restart_done_lat", n, 15);

        // Table write during RUN at IDX=1; a START while busy is ignored.
        tick(1);
        pulse_start(1, 1);
        wait_for(W_IDX1_RUN, 100, n);
        tick(1);
        write_entry(0, 4, 4);
        check("wr_run_m", M, 3);
        check("wr_run_n", N, 2);
        pulse_start(0, 5);
        wait_for(W_DONE, 100, n);
        check("busy_start_ignored_lat", n, 4);
        tick(1);
        pulse_start(0, 1);
        wait_for(W_GEN_LOW, 50, n);
        check("new_entry_m", M, 4);
        check("new_entry_n", N, 4);
        wait_for(W_DONE, 100, n);
        check("new_entry_done_lat", n, 9);

        // STOP coincident with the final boundary edge, then START+STOP together in IDLE.
        tick(1);
        pulse_start(0, 1);
        tick(10);
        STOP = 1'b1;
        tick(1);
        STOP = 1'b0;
        check("stop_edge_done", DONE, 0);
        check("stop_edge_busy", BUSY, 0);
        check("stop_edge_idx", IDX, 0);
        START = 1'b1; STOP = 1'b1;
        tick(1);
        START = 1'b0; STOP = 1'b0;
        check("start_stop_idle", BUSY, 0);

`ifdef SEQ_LOOP_EN
        write_entry(0, 2, 1);
        write_entry(1, 1, 1);
        LOOP = 1'b1;
        pulse_start(1, 1);
        wait_for(W_WRAP, 100, n);
        check("wrap1_lat", n, 12);
        wait_for(W_WRAP, 100, n);
        check("wrap2_lat", n, 11);
        tick(1);
        LOOP = 1'b0;
        wait_for(W_DONE, 100, n);
        check("loop_off_done_lat", n, 11);
`endif

        // Reset mid-sequence, then an all-skip table ends after LAST+1 LOAD cycles.
        tick(1);
        pulse_start(1, 2);
        tick(4);
        RST = 1'b0;
        tick(1);
        RST = 1'b1;
        check_reset_values("midreset");
        tick(1);
        pulse_start(3, 1);
        wait_for(W_DONE, 50, n);
        check("allskip_done_lat", n, 5);
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
